// File: rtl/svfloat_special_seq.sv
// svfloat_special_seq
// Walks all 256 ordered pairs of a 16-entry table of IEEE-754 single-precision
// special/boundary values and presents them on a shared operand bus. A
// free-running delay line tags each result cycle with the originating indices.

module svfloat_special_seq #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic [31:0] lhs,
    output logic [31:0] rhs,
    output logic [3:0]  lhs_idx,
    output logic [3:0]  rhs_idx,
    output logic        in_valid,
    output logic        res_valid,
    output logic [3:0]  res_lhs_idx,
    output logic [3:0]  res_rhs_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // DRAIN lasts LATENCY cycles: the counter starts at LATENCY-1 and exits at 0.
    localparam logic [2:0] DRAIN_LOAD = 3'(LATENCY - 1);

    logic [1:0]  state_reg, state_next;
    logic [3:0]  lhs_idx_reg, lhs_idx_next;
    logic [3:0]  rhs_idx_reg, rhs_idx_next;
    logic [2:0]  drain_cnt_reg, drain_cnt_next;
    logic [31:0] lhs_reg, rhs_reg;
    logic [7:0]  pair_inc;
    logic        issue;

    // Fixed table of special and boundary operands.
    function automatic logic [31:0] table_value(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'h0000_0000; // +0
            4'd1:    v = 32'h8000_0000; // -0
            4'd2:    v = 32'h7F80_0000; // +inf
            4'd3:    v = 32'hFF80_0000; // -inf
            4'd4:    v = 32'h7FC0_0000; // qNaN
            4'd5:    v = 32'h7F80_0001; // sNaN
            4'd6:    v = 32'h0000_0001; // +min subnormal
            4'd7:    v = 32'h807F_FFFF; // -max subnormal
            4'd8:    v = 32'h0080_0000; // +min normal
            4'd9:    v = 32'hFF7F_FFFF; // -max normal
            4'd10:   v = 32'h3F80_0000; // +1
            4'd11:   v = 32'hBF80_0000; // -1
            4'd12:   v = 32'h4000_0000; // +2
            4'd13:   v = 32'h3F00_0000; // +0.5
            4'd14:   v = 32'h7F7F_FFFF; // +max normal
            default: v = 32'h8000_0001; // -min subnormal
        endcase
        return v;
    endfunction

    assign issue    = (state_reg == ST_RUN) && !stall;
    // The index pair is treated as one 8-bit counter: rhs is the low nibble, so
    // its 15->0 wrap carries into lhs on the same edge.
    assign pair_inc = {lhs_idx_reg, rhs_idx_reg} + 8'd1;

    // Next-state and index sequencing.
    always_comb begin
        state_next     = state_reg;
        lhs_idx_next   = lhs_idx_reg;
        rhs_idx_next   = rhs_idx_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_RUN;
                    lhs_idx_next = 4'd0;
                    rhs_idx_next = 4'd0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    lhs_idx_next = pair_inc[7:4];
                    rhs_idx_next = pair_inc[3:0];
                    if (lhs_idx_reg == 4'd15 && rhs_idx_reg == 4'd15) begin
                        state_next     = ST_DRAIN;
                        drain_cnt_next = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == 3'd0) begin
                    state_next = ST_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control registers; operand words are read from the table at the next
    // index so lhs/rhs always track lhs_idx/rhs_idx without a combinational ROM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            lhs_idx_reg   <= 4'd0;
            rhs_idx_reg   <= 4'd0;
            drain_cnt_reg <= 3'd0;
            lhs_reg       <= 32'd0;
            rhs_reg       <= 32'd0;
        end else begin
            state_reg     <= state_next;
            lhs_idx_reg   <= lhs_idx_next;
            rhs_idx_reg   <= rhs_idx_next;
            drain_cnt_reg <= drain_cnt_next;
            lhs_reg       <= table_value(lhs_idx_next);
            rhs_reg       <= table_value(rhs_idx_next);
        end
    end

    // Delay line matching the arithmetic latency; never stalled, so stalls
    // emerge as res_valid bubbles exactly LATENCY cycles later.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dly
            logic [8:0] stage_reg;
            if (gi == 0) begin : g_first
                // First stage captures the issued pair.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= 9'd0;
                    end else begin
                        stage_reg <= {issue, lhs_idx_reg, rhs_idx_reg};
                    end
                end
            end else begin : g_rest
                // Later stages shift the tag along.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= 9'd0;
                    end else begin
                        stage_reg <= g_dly[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign {res_valid, res_lhs_idx, res_rhs_idx} = g_dly[LATENCY-1].stage_reg;

    assign lhs      = lhs_reg;
    assign rhs      = rhs_reg;
    assign lhs_idx  = lhs_idx_reg;
    assign rhs_idx  = rhs_idx_reg;
    assign in_valid = issue;
    assign busy     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign done     = (state_reg == ST_DONE);

endmodule
